// File: rtl/rv_mem_arb.sv
// Shares one single-outstanding memory bus between instruction fetch (F) and load/store (D).
// Fixed priority D > F with a starvation guard, plus a per-grant ack watchdog.
module rv_mem_arb #(
   parameter int STARVE_LIMIT = 2,
   parameter int TIMEOUT      = 64
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_f_cyc,
   input  logic [31:0] i_f_addr,
   output logic [31:0] o_f_data,
   output logic        o_f_ack,
   output logic        o_f_err,
   input  logic        i_d_cyc,
   input  logic        i_d_we,
   input  logic [3:0]  i_d_sel,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   output logic [31:0] o_d_rdata,
   output logic        o_d_ack,
   output logic        o_d_err,
   output logic        o_m_cyc,
   output logic        o_m_we,
   output logic [3:0]  o_m_sel,
   output logic [31:0] o_m_addr,
   output logic [31:0] o_m_wdata,
   input  logic [31:0] i_m_rdata,
   input  logic        i_m_ack,
   output logic [1:0]  o_grant
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GNT_F = 2'd1;
   localparam logic [1:0] GNT_D = 2'd2;

   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit WD_EN = (TIMEOUT > 0);

   logic [1:0]      state_q, state_d;
   logic [SC_W-1:0] starve_q, starve_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            gnt_f, gnt_d, m_cyc, ack, tmo, pick_d, pick_f;

   assign gnt_f  = (state_q == GNT_F);
   assign gnt_d  = (state_q == GNT_D);
   assign pick_d = i_d_cyc & (~i_f_cyc | (starve_q < SC_MAX));
   assign pick_f = ~pick_d & i_f_cyc;
   assign m_cyc  = (gnt_f & i_f_cyc) | (gnt_d & i_d_cyc);
   assign ack    = m_cyc & i_m_ack;
   assign tmo    = WD_EN & m_cyc & ~i_m_ack & (wd_q == WD_LAST);

   always_comb begin
      o_m_cyc   = m_cyc;
      o_m_we    = 1'b0;
      o_m_sel   = 4'h0;
      o_m_addr  = 32'h0;
      o_m_wdata = 32'h0;
      if (gnt_f) begin
         o_m_sel  = 4'hF;
         o_m_addr = i_f_addr;
      end else if (gnt_d) begin
         o_m_we    = i_d_we;
         o_m_sel   = i_d_sel;
         o_m_addr  = i_d_addr;
         o_m_wdata = i_d_wdata;
      end
   end

   assign o_f_ack   = gnt_f & ack;
   assign o_d_ack   = gnt_d & ack;
   assign o_f_data  = o_f_ack ? i_m_rdata : 32'h0;
   assign o_d_rdata = o_d_ack ? i_m_rdata : 32'h0;
   assign o_f_err   = gnt_f & tmo;
   assign o_d_err   = gnt_d & tmo;
   assign o_grant   = {gnt_d, gnt_f};

   // Re-arbitrate from IDLE or in the ack cycle itself so back-to-back grants have no bubble.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      wd_d     = '0;
      if (state_q == IDLE || ack) begin
         if (pick_d) begin
            state_d = GNT_D;
            if (!i_f_cyc)
               starve_d = '0;
            else if (starve_q != SC_MAX)
               starve_d = starve_q + SC_W'(1);
         end else if (pick_f) begin
            state_d  = GNT_F;
            starve_d = '0;
         end else begin
            state_d = IDLE;
         end
      end else if (!m_cyc || tmo) begin
         state_d = IDLE;
      end else if (wd_q != '1) begin
         wd_d = wd_q + WD_W'(1);
      end else begin
         wd_d = wd_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         starve_q <= '0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         wd_q     <= wd_d;
      end
   end
endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed scenarios followed by random traffic, all cycles checked against a transaction-level model.
module tb_rv_mem_arb;
   localparam int SL  = 2;
   localparam int TMO = 16;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_f_cyc, i_d_cyc, i_d_we, i_m_ack;
   logic [31:0] i_f_addr, i_d_addr, i_d_wdata, i_m_rdata;
   logic [3:0]  i_d_sel;
   logic [31:0] o_f_data, o_d_rdata, o_m_addr, o_m_wdata;
   logic        o_f_ack, o_f_err, o_d_ack, o_d_err, o_m_cyc, o_m_we;
   logic [3:0]  o_m_sel;
   logic [1:0]  o_grant;

   int errors = 0;
   int checks = 0;
   int owner  = 0;   // 0 none, 1 fetch, 2 data
   int d_run  = 0;   // consecutive data wins while fetch waited
   int waited = 0;   // unacked cycles in the current grant

   rv_mem_arb #(.STARVE_LIMIT(SL), .TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_f_cyc(i_f_cyc), .i_f_addr(i_f_addr), .o_f_data(o_f_data), .o_f_ack(o_f_ack), .o_f_err(o_f_err),
      .i_d_cyc(i_d_cyc), .i_d_we(i_d_we), .i_d_sel(i_d_sel), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
      .o_d_rdata(o_d_rdata), .o_d_ack(o_d_ack), .o_d_err(o_d_err),
      .o_m_cyc(o_m_cyc), .o_m_we(o_m_we), .o_m_sel(o_m_sel), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
      .i_m_rdata(i_m_rdata), .i_m_ack(i_m_ack), .o_grant(o_grant)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_cycle();
      bit busy, done, late;
      int want;
      busy = (owner == 1 && i_f_cyc) || (owner == 2 && i_d_cyc);
      done = busy && i_m_ack;
      late = busy && !i_m_ack && (waited == TMO - 1);
      chk("m_grant", {30'b0, o_grant}, (owner == 2) ? 32'd2 : (owner == 1) ? 32'd1 : 32'd0);
      chk("m_cyc", {31'b0, o_m_cyc}, {31'b0, busy});
      if (owner == 0)
         chk("m_idle_bus", o_m_addr | o_m_wdata | {27'b0, o_m_we, o_m_sel}, 32'h0);
      if (busy && owner == 1)
         chk("m_f_bus", o_m_addr ^ i_f_addr | o_m_wdata | {27'b0, o_m_we, o_m_sel ^ 4'hF}, 32'h0);
      if (busy && owner == 2)
         chk("m_d_bus", (o_m_addr ^ i_d_addr) | (o_m_wdata ^ i_d_wdata)
             | {27'b0, o_m_we ^ i_d_we, o_m_sel ^ i_d_sel}, 32'h0);
      chk("m_f_ack", {31'b0, o_f_ack}, {31'b0, done && owner == 1});
      chk("m_d_ack", {31'b0, o_d_ack}, {31'b0, done && owner == 2});
      chk("m_f_data", o_f_data, (done && owner == 1) ? i_m_rdata : 32'h0);
      chk("m_d_data", o_d_rdata, (done && owner == 2) ? i_m_rdata : 32'h0);
      chk("m_f_err", {31'b0, o_f_err}, {31'b0, late && owner == 1});
      chk("m_d_err", {31'b0, o_d_err}, {31'b0, late && owner == 2});
      if (!i_reset_n) begin
         owner = 0; d_run = 0; waited = 0;
      end else if (owner == 0 || done) begin
         want = (i_d_cyc && (!i_f_cyc || d_run < SL)) ? 2 : i_f_cyc ? 1 : 0;
         if (want == 2) d_run = i_f_cyc ? ((d_run < SL) ? d_run + 1 : SL) : 0;
         if (want == 1) d_run = 0;
         owner = want; waited = 0;
      end else if (!busy || late) begin
         owner = 0; waited = 0;
      end else begin
         waited++;
      end
   endtask

   task automatic samp();
      @(negedge i_clk);
   endtask

   task automatic adv();
      model_cycle();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [1:0] seq [6];
      seq = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
      i_reset_n = 1'b0; i_f_cyc = 0; i_d_cyc = 0; i_d_we = 0; i_m_ack = 0;
      i_f_addr = 0; i_d_addr = 0; i_d_wdata = 0; i_d_sel = 0; i_m_rdata = 0;
      repeat (2) @(posedge i_clk);
      #1;
      samp(); chk("rst_grant", {30'b0, o_grant}, 0); chk("rst_cyc", {31'b0, o_m_cyc}, 0); adv();

      // 1: fetch only, ack two cycles after grant, held cyc re-grants without bubble
      i_reset_n = 1; i_f_cyc = 1; i_f_addr = 32'h100;
      samp(); chk("t1_req_cyc", {31'b0, o_m_cyc}, 0); adv();
      samp(); chk("t1_gnt", {30'b0, o_grant}, 1); chk("t1_addr", o_m_addr, 32'h100); adv();
      samp(); adv();
      i_m_ack = 1; i_m_rdata = 32'h13;
      samp(); chk("t1_ack", {31'b0, o_f_ack}, 1); chk("t1_data", o_f_data, 32'h13); adv();
      i_m_ack = 0;
      samp(); chk("t1_b2b_gnt", {30'b0, o_grant}, 1); chk("t1_b2b_cyc", {31'b0, o_m_cyc}, 1); adv();
      i_f_cyc = 0;
      samp(); adv();

      // 2: both request, data wins and after its ack fetch follows
      i_f_cyc = 1; i_f_addr = 32'h104;
      i_d_cyc = 1; i_d_we = 1; i_d_sel = 4'hF; i_d_addr = 32'h2000; i_d_wdata = 32'hDEADBEEF;
      samp(); adv();
      i_m_ack = 1; i_m_rdata = 32'h55;
      samp(); chk("t2_gnt_d", {30'b0, o_grant}, 2); chk("t2_we", {31'b0, o_m_we}, 1);
      chk("t2_wdata", o_m_wdata, 32'hDEADBEEF); chk("t2_no_fack", {31'b0, o_f_ack}, 0); adv();
      samp(); chk("t2_gnt_d2", {30'b0, o_grant}, 2); chk("t2_no_fack2", {31'b0, o_f_ack}, 0); adv();
      i_d_cyc = 0; i_m_rdata = 32'h77;
      samp(); chk("t2_gnt_f", {30'b0, o_grant}, 1); chk("t2_fdata", o_f_data, 32'h77);
      chk("t2_f_wdata", o_m_wdata, 0); adv();
      i_f_cyc = 0; i_m_ack = 0;
      samp(); adv();

      // 3: continuous contention shows the starvation guard pattern
      i_f_cyc = 1; i_d_cyc = 1; i_d_we = 0; i_m_ack = 1;
      samp(); adv();
      for (int i = 0; i < 6; i++) begin
         samp(); chk($sformatf("t3_seq%0d", i), {30'b0, o_grant}, {30'b0, seq[i]}); adv();
      end
      i_f_cyc = 0; i_d_cyc = 0; i_m_ack = 0;
      samp(); adv();

      // 4: fetch never acked, watchdog fires on the 16th granted cycle
      i_f_cyc = 1; i_f_addr = 32'h400;
      samp(); adv();
      for (int k = 1; k <= TMO; k++) begin
         samp(); chk($sformatf("t4_err%0d", k), {31'b0, o_f_err}, {31'b0, k == TMO}); adv();
      end
      samp(); chk("t4_idle_cyc", {31'b0, o_m_cyc}, 0); chk("t4_idle_gnt", {30'b0, o_grant}, 0); adv();
      samp(); chk("t4_regrant", {30'b0, o_grant}, 1); adv();
      i_f_cyc = 0;
      samp(); adv();

      // 5: fetch flushed before ack, stale ack in IDLE ignored, new fetch served
      i_f_cyc = 1; i_f_addr = 32'h200;
      samp(); adv();
      samp(); chk("t5_addr1", o_m_addr, 32'h200); adv();
      i_f_cyc = 0;
      samp(); chk("t5_abort_cyc", {31'b0, o_m_cyc}, 0); adv();
      i_f_cyc = 1; i_f_addr = 32'h300; i_m_ack = 1; i_m_rdata = 32'hBAD;
      samp(); chk("t5_stale_ack", {31'b0, o_f_ack}, 0); chk("t5_stale_data", o_f_data, 0); adv();
      i_m_ack = 0;
      samp(); chk("t5_addr2", o_m_addr, 32'h300); adv();
      i_m_ack = 1; i_m_rdata = 32'h3003;
      samp(); chk("t5_data", o_f_data, 32'h3003); adv();
      i_f_cyc = 0; i_m_ack = 0;
      samp(); adv();

      // 6: reset mid-grant clears everything; watchdog restarts from zero
      i_d_cyc = 1; i_d_addr = 32'h600;
      samp(); adv();
      repeat (5) begin samp(); adv(); end
      i_reset_n = 0;
      samp(); chk("t6_pre_gnt", {30'b0, o_grant}, 2); adv();
      i_reset_n = 1; i_m_ack = 1;
      samp(); chk("t6_rst_gnt", {30'b0, o_grant}, 0); chk("t6_rst_cyc", {31'b0, o_m_cyc}, 0);
      chk("t6_rst_ack", {31'b0, o_d_ack}, 0); adv();
      i_m_ack = 0;
      for (int k = 1; k <= TMO; k++) begin
         samp(); chk($sformatf("t6_err%0d", k), {31'b0, o_d_err}, {31'b0, k == TMO}); adv();
      end
      i_d_cyc = 0;
      samp(); adv();

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(4) == 0) i_f_cyc = ~i_f_cyc;
         if ($urandom_range(4) == 0) i_d_cyc = ~i_d_cyc;
         i_d_we    = $urandom_range(1);
         i_d_sel   = 4'($urandom);
         i_f_addr  = $urandom;
         i_d_addr  = $urandom;
         i_d_wdata = $urandom;
         i_m_rdata = $urandom;
         i_m_ack   = ($urandom_range(3) == 0);
         i_reset_n = ($urandom_range(299) != 0);
         samp(); adv();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
